// File: rtl/jt12_pkg.sv
// Shared definitions for the JT12 prescaler: ratio encodings, the
// prescaler register addresses and the ratio-to-terminal-count mapping.
package jt12_pkg;

  typedef enum logic [1:0] {
    DIV6 = 2'b00,
    DIV2 = 2'b01,
    DIV3 = 2'b10
  } div_e;

  localparam logic [7:0] REG_PRE6 = 8'h2D;
  localparam logic [7:0] REG_PRE3 = 8'h2E;
  localparam logic [7:0] REG_PRE2 = 8'h2F;

  localparam int CNT_W = 3;

  // Last count value of a divided period (N-1) for a given ratio.
  function automatic logic [CNT_W-1:0] div_last(input div_e sel);
    case (sel)
      DIV3:    div_last = 3'd2;
      DIV2:    div_last = 3'd1;
      default: div_last = 3'd5;
    endcase
  endfunction

endpackage

// File: rtl/jt12_wr_sync.sv
// Bus write detector: registers the write condition twice and emits a
// single-cycle strobe on its rising edge, holding the bus address and data
// sampled while the write was active.
module jt12_wr_sync
  import jt12_pkg::*;
(
  input  logic       clk,
  input  logic       rst_int,
  input  logic       cs_n_i,
  input  logic       wr_n_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] din_i,
  output logic       strobe_o,
  output logic [1:0] addr_o,
  output logic [7:0] din_o
);

  logic       wrS_q, wrS_d;
  logic       wrD_q;
  logic [1:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;

  // Next-state: sample the write condition and capture the bus alongside it.
  always_comb begin
    wrS_d  = ~cs_n_i & ~wr_n_i;
    addr_d = wrS_d ? addr_i : addr_q;
    din_d  = wrS_d ? din_i  : din_q;
  end

  // Write-detect pipeline and captured bus registers.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      wrS_q  <= 1'b0;
      wrD_q  <= 1'b0;
      addr_q <= 2'b00;
      din_q  <= 8'h00;
    end else begin
      wrS_q  <= wrS_d;
      wrD_q  <= wrS_q;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  assign strobe_o = wrS_q & ~wrD_q;
  assign addr_o   = addr_q;
  assign din_o    = din_q;

endmodule

// File: rtl/jt12_prescaler_cen.sv
// JT12 prescaler: decodes writes to registers 0x2D/0x2E/0x2F, produces a
// clock enable at the selected ratio (ratio changes only at period wrap,
// so no short period can occur) and a write-busy flag timed in cen pulses.
module jt12_prescaler_cen
  import jt12_pkg::*;
#(
  parameter int BUSY_CEN = 32
) (
  input  logic       clk,
  input  logic       rst_int,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic       cen,
  output logic [1:0] div_sel,
  output logic       busy
);

  localparam int                BUSY_W    = $clog2(BUSY_CEN + 1);
  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CEN);
  localparam logic [BUSY_W-1:0] BUSY_ONE  = BUSY_W'(1);

  logic             wrStrobe;
  logic [1:0]       wrAddr;
  logic [7:0]       wrDin;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cntLast;
  logic             wrap;
  logic             cen_q, cen_d;
  div_e             divSel_q, divSel_d;
  div_e             divPend_q, divPend_d;
  logic [7:0]       regAddr_q, regAddr_d;
  logic             regPart_q, regPart_d;
  logic             busy_q, busy_d;
  logic [BUSY_W-1:0] busyCnt_q, busyCnt_d;

  jt12_wr_sync u_wr_sync (
    .clk      (clk),
    .rst_int  (rst_int),
    .cs_n_i   (cs_n),
    .wr_n_i   (wr_n),
    .addr_i   (addr),
    .din_i    (din),
    .strobe_o (wrStrobe),
    .addr_o   (wrAddr),
    .din_o    (wrDin)
  );

  // Next-state: divider with wrap-time ratio switch, register decode, busy timer.
  always_comb begin
    cntLast   = div_last(divSel_q);
    wrap      = (cnt_q == cntLast);
    cnt_d     = wrap ? '0 : cnt_q + 3'd1;
    cen_d     = wrap;
    divSel_d  = wrap ? divPend_q : divSel_q;
    divPend_d = divPend_q;
    regAddr_d = regAddr_q;
    regPart_d = regPart_q;
    busy_d    = busy_q;
    busyCnt_d = busyCnt_q;

    if (busy_q && cen_q) begin
      busyCnt_d = busyCnt_q - BUSY_ONE;
      if (busyCnt_q == BUSY_ONE) begin
        busy_d = 1'b0;
      end
    end

    if (wrStrobe) begin
      if (!wrAddr[0]) begin
        regAddr_d = wrDin;
        regPart_d = wrAddr[1];
      end else begin
        busy_d    = 1'b1;
        busyCnt_d = BUSY_LOAD;
        if (!regPart_q) begin
          case (regAddr_q)
            REG_PRE6: divPend_d = DIV6;
            REG_PRE3: divPend_d = DIV3;
            REG_PRE2: divPend_d = DIV2;
            default:  divPend_d = divPend_q;
          endcase
        end
      end
    end
  end

  // State registers; reset discards any pending ratio.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      cnt_q     <= '0;
      cen_q     <= 1'b0;
      divSel_q  <= DIV6;
      divPend_q <= DIV6;
      regAddr_q <= 8'h00;
      regPart_q <= 1'b0;
      busy_q    <= 1'b0;
      busyCnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cen_q     <= cen_d;
      divSel_q  <= divSel_d;
      divPend_q <= divPend_d;
      regAddr_q <= regAddr_d;
      regPart_q <= regPart_d;
      busy_q    <= busy_d;
      busyCnt_q <= busyCnt_d;
    end
  end

  assign cen     = cen_q;
  assign div_sel = divSel_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_jt12_prescaler_cen.sv
// Directed bench for the JT12 prescaler: cen timing, ratio switching at
// wrap, register part filtering, busy duration and asynchronous reset.
module tb_jt12_prescaler_cen;

  logic       clk = 1'b0;
  logic       rst_int = 1'b1;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [1:0] addr = 2'b00;
  logic [7:0] din = 8'h00;
  logic       cen;
  logic [1:0] div_sel;
  logic       busy;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc;
  int cenTimes[$];
  int busyPulses;
  int t0;

  jt12_prescaler_cen #(.BUSY_CEN(32)) dut (
    .clk     (clk),
    .rst_int (rst_int),
    .cs_n    (cs_n),
    .wr_n    (wr_n),
    .addr    (addr),
    .din     (din),
    .cen     (cen),
    .div_sel (div_sel),
    .busy    (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Rising edges counted since reset release.
  always @(posedge clk or posedge rst_int) begin
    if (rst_int) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One bus write cycle starting at a falling edge, followed by one idle cycle.
  task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
  endtask

  // Wait (bounded) for the next cen pulse; returns the edge index it followed.
  task automatic waitCen(input string tag, output int t);
    bit seen;
    seen = 1'b0;
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!seen && cen) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!seen) checkOutput({tag, " cen timeout"}, int'(cen), 1);
  endtask

  // Record cen edge indices and busy-qualified cen pulses for a number of cycles.
  task automatic observe(input int cycles);
    cenTimes.delete();
    busyPulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (cen) cenTimes.push_back(cyc);
      if (cen && busy) busyPulses++;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst cen", int'(cen), 0);
    checkOutput("rst div_sel", int'(div_sel), 0);
    checkOutput("rst busy", int'(busy), 0);
    rst_int = 1'b0;

    // Free-running /6 from reset release
    observe(20);
    checkOutput("div6 count", cenTimes.size(), 3);
    checkOutput("div6 first", cenTimes[0], 6);
    checkOutput("div6 second", cenTimes[1], 12);
    checkOutput("div6 third", cenTimes[2], 18);
    checkOutput("div6 div_sel", int'(div_sel), 0);
    checkOutput("div6 busy", int'(busy), 0);

    // Part 1 register write: busy asserts, ratio unchanged
    applyStimulus(2'b10, 8'h2E);
    applyStimulus(2'b11, 8'h00);
    checkOutput("part1 busy", int'(busy), 1);
    observe(20);
    checkOutput("part1 div_sel", int'(div_sel), 0);
    checkOutput("part1 period", cenTimes[1] - cenTimes[0], 6);

    // Switch to /2 mid-period; busy lasts 32 cen pulses
    waitCen("to div2", t0);
    applyStimulus(2'b00, 8'h2F);
    applyStimulus(2'b01, 8'h00);
    checkOutput("div2 busy set", int'(busy), 1);
    observe(100);
    checkOutput("div2 last div6", cenTimes[0] - t0, 6);
    checkOutput("div2 first", cenTimes[1] - t0, 8);
    checkOutput("div2 second", cenTimes[2] - t0, 10);
    checkOutput("div2 div_sel", int'(div_sel), 1);
    checkOutput("div2 busy pulses", busyPulses, 32);
    checkOutput("div2 busy clear", int'(busy), 0);

    // Pending update lands on a wrap edge: applied one old period later
    waitCen("wrap coincide", t0);
    applyStimulus(2'b00, 8'h2E);
    applyStimulus(2'b01, 8'h00);
    observe(14);
    checkOutput("coincide last div2", cenTimes[0] - t0, 6);
    checkOutput("coincide first div3", cenTimes[1] - t0, 9);
    checkOutput("coincide second div3", cenTimes[2] - t0, 12);
    checkOutput("coincide div_sel", int'(div_sel), 2);

    // Back to /6
    applyStimulus(2'b00, 8'h2D);
    applyStimulus(2'b01, 8'h00);
    observe(20);
    checkOutput("back div6 div_sel", int'(div_sel), 0);

    // Two data writes in one /6 period: last one (/3) wins
    waitCen("last wins", t0);
    repeat (3) @(negedge clk);
    applyStimulus(2'b00, 8'h2F);
    applyStimulus(2'b01, 8'h00);
    applyStimulus(2'b00, 8'h2E);
    applyStimulus(2'b01, 8'h00);
    observe(8);
    checkOutput("last wins full div6", cenTimes[0] - t0, 12);
    checkOutput("last wins div3 a", cenTimes[1] - t0, 15);
    checkOutput("last wins div3 b", cenTimes[2] - t0, 18);
    checkOutput("last wins div_sel", int'(div_sel), 2);

    // Bus held low for 10 cycles gives a single strobe
    repeat (120) @(negedge clk);
    checkOutput("hold pre busy", int'(busy), 0);
    cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'h00;
    busyPulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (i == 9) begin
        cs_n = 1'b1; wr_n = 1'b1;
      end
      if (cen && busy) busyPulses++;
    end
    checkOutput("hold busy pulses", busyPulses, 32);
    checkOutput("hold busy clear", int'(busy), 0);
    checkOutput("hold div_sel", int'(div_sel), 2);

    // Asynchronous reset during /2 with busy high
    applyStimulus(2'b00, 8'h2F);
    applyStimulus(2'b01, 8'h00);
    observe(20);
    checkOutput("pre rst div_sel", int'(div_sel), 1);
    checkOutput("pre rst busy", int'(busy), 1);
    waitCen("pre rst", t0);
    #1 rst_int = 1'b1;
    #1;
    checkOutput("async rst cen", int'(cen), 0);
    checkOutput("async rst busy", int'(busy), 0);
    checkOutput("async rst div_sel", int'(div_sel), 0);
    @(negedge clk);
    @(negedge clk);
    rst_int = 1'b0;
    observe(14);
    checkOutput("post rst first", cenTimes[0], 6);
    checkOutput("post rst second", cenTimes[1], 12);
    checkOutput("post rst div_sel", int'(div_sel), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
